command_tx: RTL and testbench

UART command transmitter that serialises one register write (8-bit address, 16-bit data) as three 8N1 bytes on a single TX line. It is the sending end of the command link that `command_rx` decodes. It drives the sine/PDM playground boards from another FPGA and provides a loopback source for `command_rx` benches. It sits between any command-producing logic (sequencer, test stimulus) and the `uart_tx` pin.

---
 rtl/command_tx_if.sv | 27 ++
 rtl/command_tx.sv | 136 +++++++++++++
 tb/tb_command_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/command_tx_if.sv
// Command request/handshake bundle between a command producer and command_tx.
// Handshake: the producer raises cmd_en for one cycle with cmd_addr/cmd_data
// valid; the transmitter accepts it only when busy=0 (busy acts as !ready).
// cmd_done pulses for one cycle when the final stop bit of a packet completes.
interface command_tx_if;
   logic        cmd_en;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        busy;
   logic        cmd_done;

   modport master (
      output cmd_en,
      output cmd_addr,
      output cmd_data,
      input  busy,
      input  cmd_done
   );

   modport slave (
      input  cmd_en,
      input  cmd_addr,
      input  cmd_data,
      output busy,
      output cmd_done
   );
endinterface

// File: rtl/command_tx.sv
// UART command transmitter: sends one register write as three 8N1 bytes
// (address, data high, data low), each LSB first, back-to-back.
// All outputs are registered; the FSM state is exposed on o_dbg_state.
module command_tx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic         i_clk,
   input  logic         rst,
   command_tx_if.slave  cmd,
   output logic         uart_tx,
   output logic [1:0]   o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [15:0] LP_BAUD_LAST = 16'(BAUD_DIV - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_tx;
   logic        r_busy;
   logic        r_done;
   logic        w_tx_nxt;
   logic        w_busy_nxt;
   logic        w_done_nxt;
   logic [15:0] r_baud;
   logic [2:0]  r_bit;
   logic [1:0]  r_byte;
   // Bytes are stored low-to-high in send order so the line always takes
   // bit 0; after eight data shifts the next byte sits in [7:0].
   logic [23:0] r_shift;
   logic        w_accept;
   logic        w_baud_wrap;

   assign w_accept    = (r_state == S_IDLE) && cmd.cmd_en;
   assign w_baud_wrap = (r_baud == LP_BAUD_LAST);

   // Next state and next registered line/status values.
   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = r_tx;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt   = 1'b1;
            w_busy_nxt = 1'b0;
            if (cmd.cmd_en) begin
               w_state_nxt = S_START;
               w_tx_nxt    = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         S_START: begin
            if (w_baud_wrap) begin
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_baud_wrap) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  // r_shift[0] is the bit on the line now; [1] goes next.
                  w_tx_nxt = r_shift[1];
               end
            end
         end
         S_STOP: begin
            if (w_baud_wrap) begin
               if (r_byte == 2'd2) begin
                  w_state_nxt = S_IDLE;
                  w_tx_nxt    = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_START;
                  w_tx_nxt    = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State, outputs, counters and shift register; reset wins over cmd_en.
   always_ff @(posedge i_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= {cmd.cmd_data[7:0], cmd.cmd_data[15:8], cmd.cmd_addr};
         end else if (r_state != S_IDLE) begin
            r_baud <= w_baud_wrap ? 16'd0 : r_baud + 16'd1;
            if (w_baud_wrap && (r_state == S_DATA)) begin
               r_shift <= {1'b0, r_shift[23:1]};
               r_bit   <= (r_bit == 3'd7) ? 3'd0 : r_bit + 3'd1;
            end
            if (w_baud_wrap && (r_state == S_STOP)) begin
               r_byte <= (r_byte == 2'd2) ? 2'd0 : r_byte + 2'd1;
            end
         end
      end
   end

   assign uart_tx      = r_tx;
   assign cmd.busy     = r_busy;
   assign cmd.cmd_done = r_done;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_command_tx.sv
// Bench for command_tx at BAUD_DIV=4: directed and random packets checked
// cycle by cycle against a bit-position model, plus a UART byte decoder
// feeding a scoreboard.
module tb_command_tx;
   localparam int B = 4;

   logic        i_clk;
   logic        rst;
   logic        uart_tx;
   logic [1:0]  dbg_state;
   int          checks;
   int          errors;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];

   command_tx_if cmd_if ();

   command_tx #(.BAUD_DIV(B)) dut (
      .i_clk       (i_clk),
      .rst         (rst),
      .cmd         (cmd_if.slave),
      .uart_tx     (uart_tx),
      .o_dbg_state (dbg_state)
   );

   // Clock generation.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference: line level at cycle T+rel for a packet accepted at cycle T.
   function automatic logic exp_tx(input int rel, input logic [7:0] a, input logic [15:0] d);
      int bp;
      int k;
      int j;
      logic [7:0] by;
      if (rel < 1 || rel > 30 * B) return 1'b1;
      bp = (rel - 1) / B;
      k  = bp / 10;
      j  = bp % 10;
      by = (k == 0) ? a : (k == 1) ? d[15:8] : d[7:0];
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return by[j-1];
   endfunction

   task automatic chk(input string tag, input int rel, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s rel=%0d got=%0h exp=%0h", tag, rel, got, exp);
      end
   endtask

   task automatic chk_idle_now(input string tag, input int rel);
      chk({tag, "_tx"},   rel, {31'd0, uart_tx},         32'd1);
      chk({tag, "_busy"}, rel, {31'd0, cmd_if.busy},     32'd0);
      chk({tag, "_done"}, rel, {31'd0, cmd_if.cmd_done}, 32'd0);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 1; i <= n; i++) begin
         @(negedge i_clk);
         chk_idle_now(tag, i);
      end
   endtask

   // Called at a negedge: presents a command, then checks len cycles.
   // poke_at>0 pulses a competing cmd_en at T+poke_at; rst_at>0 asserts rst
   // at T+rst_at (after which the line must be idle).
   task automatic run_pkt(input logic [7:0] a, input logic [15:0] d, input int len,
                          input int poke_at, input int rst_at, input string tag);
      logic rst_seen;
      rst_seen = 1'b0;
      cmd_if.cmd_en   = 1'b1;
      cmd_if.cmd_addr = a;
      cmd_if.cmd_data = d;
      for (int rel = 1; rel <= len; rel++) begin
         @(negedge i_clk);
         if (rel == 1 || rel == poke_at + 1) begin
            cmd_if.cmd_en   = 1'b0;
            cmd_if.cmd_addr = 8'($urandom);
            cmd_if.cmd_data = 16'($urandom);
         end
         if (rst_at > 0 && rel == rst_at + 1) begin
            rst_seen = 1'b1;
            rst = 1'b0;
         end
         if (rst_seen) begin
            chk_idle_now({tag, "_rst"}, rel);
         end else begin
            chk({tag, "_tx"},   rel, {31'd0, uart_tx}, {31'd0, exp_tx(rel, a, d)});
            chk({tag, "_busy"}, rel, {31'd0, cmd_if.busy},
                {31'd0, (rel >= 1 && rel <= 30 * B)});
            chk({tag, "_done"}, rel, {31'd0, cmd_if.cmd_done}, {31'd0, (rel == 30 * B + 1)});
         end
         if (rel == poke_at) begin
            cmd_if.cmd_en   = 1'b1;
            cmd_if.cmd_addr = 8'($urandom);
            cmd_if.cmd_data = 16'($urandom);
         end
         if (rel == rst_at) rst = 1'b1;
      end
      exp_q.push_back(a);
      if (rst_at == 0) begin
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
      end
   endtask

   task automatic compare_bytes(input string tag);
      int n;
      logic [7:0] e;
      logic [7:0] g;
      n = exp_q.size();
      chk({tag, "_nbytes"}, 0, 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         chk({tag, "_byte"}, i, {24'd0, g}, {24'd0, e});
      end
      got_q.delete();
   endtask

   // UART monitor: samples each bit at its centre, drops frames cut by reset.
   always begin : uart_decoder
      logic [7:0] byte_v;
      logic       frame_ok;
      @(negedge i_clk);
      if (uart_tx === 1'b0 && rst === 1'b0) begin
         frame_ok = 1'b1;
         byte_v   = 8'd0;
         for (int c = 1; c <= 9 * B + 2; c++) begin
            @(negedge i_clk);
            if (rst !== 1'b0) frame_ok = 1'b0;
            if (c == 2 && uart_tx !== 1'b0) frame_ok = 1'b0;
            if (c >= 2 + B && c <= 2 + 8 * B && ((c - 2) % B) == 0)
               byte_v[(c - 2) / B - 1] = uart_tx;
            if (c == 2 + 9 * B && uart_tx !== 1'b1) frame_ok = 1'b0;
         end
         if (frame_ok) got_q.push_back(byte_v);
      end
   end

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      cmd_if.cmd_en   = 1'b0;
      cmd_if.cmd_addr = 8'd0;
      cmd_if.cmd_data = 16'd0;

      // Reset held 5 cycles, then 200 idle cycles.
      repeat (5) @(negedge i_clk);
      chk_idle_now("reset", 0);
      chk("reset_state", 0, {30'd0, dbg_state}, 32'd0);
      rst = 1'b0;
      idle_cycles(200, "idle");
      compare_bytes("idle");

      // Single packet 0x01 / 0x001C.
      run_pkt(8'h01, 16'h001C, 30 * B + 1, 0, 0, "single");
      idle_cycles(10, "single_post");
      compare_bytes("single");

      // Back-to-back: second accepted on the cmd_done cycle.
      run_pkt(8'h02, 16'h0400, 30 * B + 1, 0, 0, "b2b_a");
      run_pkt(8'hA5, 16'hFFFF, 30 * B + 1, 0, 0, "b2b_b");
      idle_cycles(10, "b2b_post");
      compare_bytes("b2b");

      // Request while busy is ignored.
      run_pkt(8'h01, 16'h1234, 30 * B + 20, 50, 0, "busyreq");
      compare_bytes("busyreq");

      // Reset mid-packet (byte 1 data), then a fresh command.
      run_pkt(8'h3C, 16'h5AA5, 30 * B + 10, 0, 50, "midrst");
      compare_bytes("midrst");
      idle_cycles(3, "midrst_post");
      run_pkt(8'h7E, 16'h8001, 30 * B + 1, 0, 0, "after_rst");
      compare_bytes("after_rst");

      // cmd_en together with rst: reset wins.
      @(negedge i_clk);
      rst             = 1'b1;
      cmd_if.cmd_en   = 1'b1;
      cmd_if.cmd_addr = 8'h55;
      cmd_if.cmd_data = 16'hAAAA;
      @(negedge i_clk);
      rst           = 1'b0;
      cmd_if.cmd_en = 1'b0;
      chk_idle_now("rst_cmd", 0);
      idle_cycles(30, "rst_cmd_post");
      compare_bytes("rst_cmd");

      // Random packets with random idle gaps.
      for (int p = 0; p < 6; p++) begin
         run_pkt(8'($urandom), 16'($urandom), 30 * B + 1, 0, 0, "rand");
         idle_cycles($urandom_range(1, 12), "rand_gap");
      end
      compare_bytes("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
